mux3_valve_driver: RTL and testbench
====================================

# mux3_valve_driver

Sequential control-line driver for the 3-level, 8-channel binary-tree valve multiplexer. It accepts a channel-select request over a valid/ready handshake and drives the eight pneumatic control lines (`c_0_0` … `c_3_1`) with a break-before-make sequence: all valves close, a new path opens, then the block waits out a settle interval. It sits between the protocol/scheduler logic and the multiplexer's control inputs.

## Interface
- `CLOSE_CYC`, default 4: cycles all valves are held closed before a new path opens; legal range ≥1.
- `SETTLE_CYC`, default 8: cycles the new path pattern is held before completion; legal range ≥1.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request.
- `req_sel` in 3: target channel index i, routing `k_3_i` to `k_0_0`.
- `req_off` in 1: request to close all paths; `req_sel` is ignored.
- `done` out 1: one-cycle pulse when a request completes.
- `path_open` out 1: a path is currently established.
- `cur_sel` out 3: channel of the established path; holds its last value when `path_open` is 0.
- `c_0_0`, `c_0_1` out 1 each: level-0 gate/status pair. `c_0_0` is the inverse of `path_open`; `c_0_1` equals `path_open`.
- `c_1_0`, `c_1_1`, `c_2_0`, `c_2_1`, `c_3_0`, `c_3_1` out 1 each: valve air lines. 1 = pressurized (valve closed), 0 = vented (valve open).

## Operation
- **Bit mapping.**
  - Level 1 uses `sel[2]`, level 2 uses `sel[1]`, level 3 uses `sel[0]`.
  - Open pattern for level L with bit b: `c_L_b` = 0 and `c_L_(1-b)` = 1.
- **All-closed pattern.** Every `c_1_*`, `c_2_*` and `c_3_*` line is 1.
- **States:** IDLE, CLOSE, OPEN, DONE.
- **IDLE**
  - `req_ready` = 1. The current pattern is held (open pattern if `path_open` = 1, otherwise all-closed).
  - Handshake completes when `req_valid` and `req_ready` are both 1.
  - If `req_off` = 0, `path_open` = 1 and `req_sel` equals `cur_sel`: go to DONE. No line changes.
  - Any other accepted request: go to CLOSE and load the counter with `CLOSE_CYC` − 1.
- **CLOSE**
  - Drive the all-closed pattern. `path_open` = 0, `req_ready` = 0.
  - When the counter reaches 0:
    - if `req_off` was latched, go to DONE;
    - otherwise go to OPEN and load the counter with `SETTLE_CYC` − 1.
- **OPEN**
  - Drive the open pattern for the latched `sel`. `path_open` stays 0.
  - When the counter reaches 0, go to DONE.
- **DONE**
  - `done` = 1 for exactly one cycle, then return to IDLE. `req_ready` = 0 in this cycle.
  - On a select request: `path_open` = 1 and `cur_sel` = latched `sel`.
  - On an off request: `path_open` = 0.
- **Latching.** `req_sel` and `req_off` are latched at the handshake. Input changes after acceptance have no effect.
- **Registered outputs.** All outputs come directly from registers; there are no combinational paths from inputs.
- **Counter.** Width is `$clog2(max(CLOSE_CYC, SETTLE_CYC))` + 1. It never wraps; it is loaded only on state entry.
- **Reset**
  - Values: `req_ready` = 1, `done` = 0, `path_open` = 0, `cur_sel` = 0, `c_0_0` = 1, `c_0_1` = 0, all other lines 1.
  - Reset asserted mid-sequence aborts the sequence. The reset values appear at the next edge and no `done` is issued.

## Timing
- Handshake at edge T (select, new path):
  - edges T+1 … T+`CLOSE_CYC`: all-closed pattern;
  - next `SETTLE_CYC` cycles: open pattern;
  - `done` = 1 in cycle T+`CLOSE_CYC`+`SETTLE_CYC`+1;
  - `req_ready` = 1 again in the cycle after that.
- Latency:
  - select request: `CLOSE_CYC` + `SETTLE_CYC` + 1;
  - off request: `CLOSE_CYC` + 1;
  - same-channel request: 1.
- Back-to-back requests: the earliest next acceptance is the cycle after `done`.
- `req_valid` held high with no acceptance is legal; the request waits until `req_ready` = 1.

## Test plan
- **Reset then select channel 5** (`CLOSE_CYC` = 4, `SETTLE_CYC` = 8), accept at cycle 0 → cycles 1–4 all lines 1; cycles 5–12 `c_1_1`=0, `c_1_0`=1, `c_2_0`=0, `c_2_1`=1, `c_3_1`=0, `c_3_0`=1; `done` at cycle 13 with `path_open`=1, `cur_sel`=5, `c_0_0`=0, `c_0_1`=1.
- **Switch 5 → 2 while open** → 4 cycles all-closed (no overlap of old and new patterns); then `c_1_0`=0, `c_2_1`=0, `c_3_0`=0 for 8 cycles; `done` 13 cycles after acceptance.
- **Same-channel request** (`sel`=2 while channel 2 is open) → `done` on the next cycle; all control lines unchanged on every cycle.
- **Off request** while channel 2 is open → all lines 1 from the next cycle; `done` 5 cycles after acceptance; `path_open`=0, `c_0_0`=1.
- **`rst_n` low during OPEN**, then high → next edge shows all reset values; no `done` pulse; a new request for channel 7 completes normally in 13 cycles.
- **`req_sel` toggled after acceptance** and `req_valid` held high through the busy period → the latched channel is opened; the second request is accepted only in the cycle after `done`.

Source files
------------

// File: rtl/mux3_valve_driver.sv
// -----------------------------------------------------------------------------
// mux3_valve_driver
//
// Break-before-make control-line driver for a 3-level, 8-channel binary-tree
// pneumatic valve multiplexer. A channel-select (or all-off) request is taken
// over a valid/ready handshake. Every valve is closed for CLOSE_CYC cycles, the
// new path is opened and held for SETTLE_CYC cycles, and then done_o pulses.
// A request for the channel that is already open completes in one cycle and
// leaves the lines untouched.
//
// Handshake: a request transfers on a rising edge where req_valid_i and
// req_ready_o are both 1. req_sel_i/req_off_i are captured on that edge and
// ignored afterwards. req_ready_o is 1 only while idle. req_valid_i may stay
// high while req_ready_o is 0; the request then waits.
//
// Ports
//   clk_i                 clock, rising edge
//   rst_ni                synchronous active-low reset
//   req_valid_i           request present
//   req_ready_o           block can accept a request
//   req_sel_i[2:0]        target channel i (routes k_3_i to k_0_0)
//   req_off_i             close all paths (req_sel_i ignored)
//   done_o                one-cycle pulse on request completion
//   path_open_o           a path is established
//   cur_sel_o[2:0]        channel of the established path (holds when closed)
//   c_0_0_o, c_0_1_o      level-0 status pair: ~path_open, path_open
//   c_1_0_o .. c_3_1_o    valve air lines, 1 = pressurized (closed),
//                         0 = vented (open)
//   dbg_state_o[1:0]      current FSM state (IDLE=0, CLOSE=1, OPEN=2, DONE=3)
//
// All outputs are driven directly from registers.
// -----------------------------------------------------------------------------
module mux3_valve_driver #(
    parameter int CLOSE_CYC  = 4,
    parameter int SETTLE_CYC = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic [2:0] req_sel_i,
    input  logic       req_off_i,
    output logic       done_o,
    output logic       path_open_o,
    output logic [2:0] cur_sel_o,
    output logic       c_0_0_o,
    output logic       c_0_1_o,
    output logic       c_1_0_o,
    output logic       c_1_1_o,
    output logic       c_2_0_o,
    output logic       c_2_1_o,
    output logic       c_3_0_o,
    output logic       c_3_1_o,
    output logic [1:0] dbg_state_o
);

    localparam int MAX_CYC = (CLOSE_CYC > SETTLE_CYC) ? CLOSE_CYC : SETTLE_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] CLOSE_LOAD  = CNT_W'(CLOSE_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    // Line vector order: {c_1_0, c_1_1, c_2_0, c_2_1, c_3_0, c_3_1}
    localparam logic [5:0] ALL_CLOSED = 6'b111111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLOSE = 2'd1,
        OPEN  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Level 1 steers on sel[2], level 2 on sel[1], level 3 on sel[0].
    // For branch bit b, c_L_b is vented (0) and c_L_(1-b) stays pressurized,
    // so c_L_0 simply equals b and c_L_1 equals ~b.
    function automatic logic [5:0] open_pattern(input logic [2:0] s);
        return {s[2], ~s[2], s[1], ~s[1], s[0], ~s[0]};
    endfunction

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       sel_q;
    logic             off_q;
    logic             ready_q;
    logic             done_q;
    logic             path_open_q;
    logic [2:0]       cur_sel_q;
    logic             c_0_0_q;
    logic             c_0_1_q;
    logic [5:0]       lines_q;

    // Same-channel shortcut: nothing to close or reopen.
    logic same_path_d;
    assign same_path_d = !req_off_i && path_open_q && (req_sel_i == cur_sel_q);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sel_q       <= 3'd0;
            off_q       <= 1'b0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            path_open_q <= 1'b0;
            cur_sel_q   <= 3'd0;
            c_0_0_q     <= 1'b1;
            c_0_1_q     <= 1'b0;
            lines_q     <= ALL_CLOSED;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid_i && ready_q) begin
                        sel_q   <= req_sel_i;
                        off_q   <= req_off_i;
                        ready_q <= 1'b0;
                        if (same_path_d) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            // Break: drop the old path before anything opens.
                            state_q     <= CLOSE;
                            cnt_q       <= CLOSE_LOAD;
                            lines_q     <= ALL_CLOSED;
                            path_open_q <= 1'b0;
                            c_0_0_q     <= 1'b1;
                            c_0_1_q     <= 1'b0;
                        end
                    end
                end
                CLOSE: begin
                    if (cnt_q == '0) begin
                        if (off_q) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= OPEN;
                            cnt_q   <= SETTLE_LOAD;
                            lines_q <= open_pattern(sel_q);
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                OPEN: begin
                    if (cnt_q == '0) begin
                        // Path is only reported once it has settled.
                        state_q     <= DONE;
                        done_q      <= 1'b1;
                        path_open_q <= 1'b1;
                        cur_sel_q   <= sel_q;
                        c_0_0_q     <= 1'b0;
                        c_0_1_q     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready_o = ready_q;
    assign done_o      = done_q;
    assign path_open_o = path_open_q;
    assign cur_sel_o   = cur_sel_q;
    assign c_0_0_o     = c_0_0_q;
    assign c_0_1_o     = c_0_1_q;
    assign c_1_0_o     = lines_q[5];
    assign c_1_1_o     = lines_q[4];
    assign c_2_0_o     = lines_q[3];
    assign c_2_1_o     = lines_q[2];
    assign c_3_0_o     = lines_q[1];
    assign c_3_1_o     = lines_q[0];
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mux3_valve_driver.sv
module tb_mux3_valve_driver;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_sel;
    logic       req_off;
    logic       done;
    logic       path_open;
    logic [2:0] cur_sel;
    logic       c_0_0, c_0_1, c_1_0, c_1_1, c_2_0, c_2_1, c_3_0, c_3_1;
    logic [1:0] dbg_state;
    logic [5:0] lines;

    assign lines = {c_1_0, c_1_1, c_2_0, c_2_1, c_3_0, c_3_1};

    mux3_valve_driver #(.CLOSE_CYC(4), .SETTLE_CYC(8)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_sel_i   (req_sel),
        .req_off_i   (req_off),
        .done_o      (done),
        .path_open_o (path_open),
        .cur_sel_o   (cur_sel),
        .c_0_0_o     (c_0_0),
        .c_0_1_o     (c_0_1),
        .c_1_0_o     (c_1_0),
        .c_1_1_o     (c_1_1),
        .c_2_0_o     (c_2_0),
        .c_2_1_o     (c_2_1),
        .c_3_0_o     (c_3_0),
        .c_3_1_o     (c_3_1),
        .dbg_state_o (dbg_state)
    );

    // Hand-computed line patterns, order {c_1_0,c_1_1,c_2_0,c_2_1,c_3_0,c_3_1}
    localparam logic [5:0] P_CLOSED = 6'b111111;
    localparam logic [5:0] P_CH0    = 6'b010101;
    localparam logic [5:0] P_CH1    = 6'b010110;
    localparam logic [5:0] P_CH2    = 6'b011001;
    localparam logic [5:0] P_CH4    = 6'b100101;
    localparam logic [5:0] P_CH5    = 6'b100110;
    localparam logic [5:0] P_CH7    = 6'b101010;

    int checks   = 0;
    int failures = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, 16'(req_ready), 16'd1);
        check({tag, "_done"}, 16'(done), 16'd0);
        check({tag, "_path_open"}, 16'(path_open), 16'd0);
        check({tag, "_cur_sel"}, 16'(cur_sel), 16'd0);
        check({tag, "_c0"}, 16'({c_0_0, c_0_1}), 16'b10);
        check({tag, "_lines"}, 16'(lines), 16'(P_CLOSED));
        check({tag, "_state"}, 16'(dbg_state), 16'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [2:0] sel;
        logic       off;
        int         n_close;   // cycles expected all-closed after accept
        int         n_open;    // cycles expected with the open pattern
        logic [5:0] pat;       // pattern during open phase and at done
        logic       exp_path;  // path_open at done
        logic [2:0] exp_cur;   // cur_sel at done
    } vec_t;

    vec_t vecs[8];

    // Driver + per-cycle checker for one request accepted on the next edge.
    task automatic do_req(input vec_t v, input string tag);
        int lat;
        lat = v.n_close + v.n_open + 1;
        check({tag, "_ready_before"}, 16'(req_ready), 16'd1);
        req_sel   = v.sel;
        req_off   = v.off;
        req_valid = 1'b1;
        step();
        // Request is now latched; scramble the inputs.
        req_valid = 1'b0;
        req_sel   = 3'($urandom_range(0, 7));
        req_off   = 1'($urandom_range(0, 1));
        for (int k = 1; k <= lat; k++) begin
            if (k <= v.n_close)
                check({tag, "_lines_close"}, 16'(lines), 16'(P_CLOSED));
            else
                check({tag, "_lines_open"}, 16'(lines), 16'(v.pat));
            check({tag, "_done"}, 16'(done), 16'(k == lat));
            check({tag, "_ready_busy"}, 16'(req_ready), 16'd0);
            if (k == lat) begin
                check({tag, "_path_open"}, 16'(path_open), 16'(v.exp_path));
                check({tag, "_cur_sel"}, 16'(cur_sel), 16'(v.exp_cur));
                check({tag, "_c0"}, 16'({c_0_0, c_0_1}), 16'({~v.exp_path, v.exp_path}));
            end else begin
                step();
            end
        end
        step();
        check({tag, "_ready_after"}, 16'(req_ready), 16'd1);
        check({tag, "_done_after"}, 16'(done), 16'd0);
    endtask

    initial begin
        vecs[0] = '{3'd5, 1'b0, 4, 8, P_CH5,    1'b1, 3'd5};  // select 5 from reset
        vecs[1] = '{3'd2, 1'b0, 4, 8, P_CH2,    1'b1, 3'd2};  // switch 5 -> 2
        vecs[2] = '{3'd2, 1'b0, 0, 0, P_CH2,    1'b1, 3'd2};  // same channel
        vecs[3] = '{3'd0, 1'b1, 4, 0, P_CLOSED, 1'b0, 3'd2};  // off while 2 open
        vecs[4] = '{3'd0, 1'b0, 4, 8, P_CH0,    1'b1, 3'd0};  // select 0
        vecs[5] = '{3'd5, 1'b1, 4, 0, P_CLOSED, 1'b0, 3'd0};  // off, sel ignored
        vecs[6] = '{3'd6, 1'b1, 4, 0, P_CLOSED, 1'b0, 3'd0};  // off while closed
        vecs[7] = '{3'd7, 1'b0, 4, 8, P_CH7,    1'b1, 3'd7};  // select 7 after reset

        req_valid = 1'b0;
        req_sel   = 3'd0;
        req_off   = 1'b0;
        rst_n     = 1'b0;
        step();
        step();
        check_reset_values("reset");
        rst_n = 1'b1;
        step();
        check_reset_values("post_reset");

        for (int i = 0; i < 7; i++) begin
            do_req(vecs[i], $sformatf("vec%0d", i));
        end

        // -------- reset during OPEN aborts the sequence --------
        req_sel   = 3'd3;
        req_off   = 1'b0;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        for (int k = 1; k < 7; k++) step();
        check("midrst_in_open", 16'(lines), 16'b011010);
        rst_n = 1'b0;
        step();
        check_reset_values("midrst");
        rst_n = 1'b1;
        begin
            int seen_done;
            seen_done = 0;
            for (int k = 0; k < 16; k++) begin
                step();
                if (done) seen_done++;
            end
            check("midrst_no_done", 16'(seen_done), 16'd0);
        end
        do_req(vecs[7], "after_rst_ch7");

        // -------- req_valid held, req_sel toggled after acceptance --------
        begin
            int k;
            int done_cyc;
            done_cyc  = -1;
            req_sel   = 3'd1;
            req_off   = 1'b0;
            req_valid = 1'b1;
            step();                       // accepted here (channel 1)
            for (k = 1; k <= 40; k++) begin
                if (done) begin
                    done_cyc = k;
                    break;
                end
                check("held_ready_busy", 16'(req_ready), 16'd0);
                if (k == 12) check("held_lines_open", 16'(lines), 16'(P_CH1));
                req_sel = 3'($urandom_range(0, 7));
                step();
            end
            check("held_done_cycle", 16'(done_cyc), 16'd13);
            check("held_cur_sel", 16'(cur_sel), 16'd1);
            check("held_lines_done", 16'(lines), 16'(P_CH1));
            check("held_ready_in_done", 16'(req_ready), 16'd0);
            req_sel = 3'd4;               // the waiting request
            step();
            check("held_ready_after_done", 16'(req_ready), 16'd1);
            step();
            check("held_second_accepted", 16'(req_ready), 16'd0);
            check("held_second_closed", 16'(lines), 16'(P_CLOSED));
            req_valid = 1'b0;
            done_cyc  = -1;
            for (k = 2; k <= 40; k++) begin
                step();
                if (done) begin
                    done_cyc = k;
                    break;
                end
            end
            check("second_done_cycle", 16'(done_cyc), 16'd13);
            check("second_cur_sel", 16'(cur_sel), 16'd4);
            check("second_lines", 16'(lines), 16'(P_CH4));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
